// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and the 4-bit ALU
// operation codes carried down the pipeline.
package cpu_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_REG_AW = 4;
    localparam int ALU_OP_W       = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD        = 4'd0,
        ALU_SUB        = 4'd1,
        ALU_EVEN_UPPER = 4'd2,
        ALU_EVEN_LOWER = 4'd3,
        ALU_GTE        = 4'd4,
        ALU_LTZ        = 4'd5,
        ALU_EZ         = 4'd6,
        ALU_EQ         = 4'd7,
        ALU_NE         = 4'd8
    } alu_op_t;

endpackage

// File: rtl/fwd_unit.sv
// Per-operand forwarding unit: detects whether the source register is being
// produced by the instruction in EX or in MEM and picks the operand value.
// Macro ID_EX_FORWARD_EN enables bypassing; without it the register-file
// value is always used and the matches only feed the stall logic.
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int REG_AW = DEFAULT_REG_AW
) (
    input  logic              use_rs,
    input  logic [REG_AW-1:0] rs,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_data,
    output logic              ex_match,
    output logic              mem_match,
    output logic [DATA_W-1:0] operand
);

    logic rs_live;

    // A source only counts when it is actually read and is not register 0.
    always_comb begin
        rs_live   = use_rs && (rs != '0);
        ex_match  = rs_live && ex_valid && ex_reg_write && (ex_dest == rs);
        mem_match = rs_live && mem_reg_write && (mem_dest == rs);
    end

`ifdef ID_EX_FORWARD_EN
    // EX result is youngest so it wins; a load in EX has no result yet.
    always_comb begin
        operand = rf_data;
        if (ex_match && !ex_mem_read) begin
            operand = alu_result;
        end else if (mem_match) begin
            operand = mem_data;
        end
    end
`else
    logic unused_fwd;

    // Without bypassing, hazards are resolved by stalling, so the register
    // file value is always correct once the stage is allowed to load.
    always_comb begin
        operand    = rf_data;
        unused_fwd = ^{ex_mem_read, alu_result, mem_data};
    end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and hazard detection.
// Macro ID_EX_FORWARD_EN: defined -> EX/MEM bypassing with load-use stall;
// undefined -> no bypassing, stall on any EX or MEM dependency.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int REG_AW = DEFAULT_REG_AW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic [ALU_OP_W-1:0] op_in,
    input  logic [REG_AW-1:0]   rs0_in,
    input  logic [REG_AW-1:0]   rs1_in,
    input  logic                use_rs0_in,
    input  logic                use_rs1_in,
    input  logic [DATA_W-1:0]   rf_data0_in,
    input  logic [DATA_W-1:0]   rf_data1_in,
    input  logic [REG_AW-1:0]   dest_in,
    input  logic                reg_write_in,
    input  logic                mem_read_in,
    input  logic                stall_in,
    input  logic                flush_in,
    input  logic [DATA_W-1:0]   alu_result_in,
    input  logic [REG_AW-1:0]   mem_dest_in,
    input  logic                mem_reg_write_in,
    input  logic [DATA_W-1:0]   mem_data_in,
    output logic                valid_out,
    output logic [ALU_OP_W-1:0] operation,
    output logic [DATA_W-1:0]   readData0,
    output logic [DATA_W-1:0]   readData1,
    output logic [REG_AW-1:0]   dest_out,
    output logic                reg_write_out,
    output logic                mem_read_out,
    output logic                hazard_stall
);

    logic              ex_match0, ex_match1;
    logic              mem_match0, mem_match1;
    logic [DATA_W-1:0] operand0, operand1;

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd0 (
        .use_rs        (use_rs0_in),
        .rs            (rs0_in),
        .rf_data       (rf_data0_in),
        .ex_valid      (valid_out),
        .ex_reg_write  (reg_write_out),
        .ex_mem_read   (mem_read_out),
        .ex_dest       (dest_out),
        .alu_result    (alu_result_in),
        .mem_reg_write (mem_reg_write_in),
        .mem_dest      (mem_dest_in),
        .mem_data      (mem_data_in),
        .ex_match      (ex_match0),
        .mem_match     (mem_match0),
        .operand       (operand0)
    );

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
        .use_rs        (use_rs1_in),
        .rs            (rs1_in),
        .rf_data       (rf_data1_in),
        .ex_valid      (valid_out),
        .ex_reg_write  (reg_write_out),
        .ex_mem_read   (mem_read_out),
        .ex_dest       (dest_out),
        .alu_result    (alu_result_in),
        .mem_reg_write (mem_reg_write_in),
        .mem_dest      (mem_dest_in),
        .mem_data      (mem_data_in),
        .ex_match      (ex_match1),
        .mem_match     (mem_match1),
        .operand       (operand1)
    );

    // Hazard request; a flush kills the incoming instruction so never stalls it.
    always_comb begin
`ifdef ID_EX_FORWARD_EN
        hazard_stall = valid_in && !flush_in && mem_read_out && (ex_match0 || ex_match1);
`else
        hazard_stall = valid_in && !flush_in &&
                       (ex_match0 || ex_match1 || mem_match0 || mem_match1);
`endif
    end

    // Pipeline register: reset > flush > downstream stall > bubble > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
            mem_read_out  <= 1'b0;
            operation     <= '0;
            readData0     <= '0;
            readData1     <= '0;
            dest_out      <= '0;
        end else if (flush_in) begin
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
            mem_read_out  <= 1'b0;
        end else if (stall_in) begin
            valid_out     <= valid_out;
        end else if (hazard_stall) begin
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
            mem_read_out  <= 1'b0;
        end else begin
            valid_out     <= valid_in;
            reg_write_out <= valid_in && reg_write_in;
            mem_read_out  <= valid_in && mem_read_in;
            operation     <= op_in;
            readData0     <= operand0;
            readData1     <= operand1;
            dest_out      <= dest_in;
        end
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width.
REQ-002 SHALL have parameter REG_AW, default 4, register-address width (register 0 hardwired zero).
REQ-003 SHALL have port clk input 1, single clock; all state on rising edge.
REQ-004 SHALL have port reset input 1, synchronous, active-high.
REQ-005 SHALL have ports valid_in input 1; op_in input 4 (ALU operation code); rs0_in, rs1_in input REG_AW; use_rs0_in, use_rs1_in input 1; rf_data0_in, rf_data1_in input DATA_W; dest_in input REG_AW; reg_write_in, mem_read_in input 1.
REQ-006 SHALL have ports stall_in input 1 (downstream hold); flush_in input 1 (taken branch resolved in EX).
REQ-007 SHALL have ports alu_result_in input DATA_W (combinational ALU result of the instruction held here); mem_dest_in input REG_AW; mem_reg_write_in input 1; mem_data_in input DATA_W.
REQ-008 SHALL have registered outputs valid_out 1, operation 4, readData0 DATA_W, readData1 DATA_W, dest_out REG_AW, reg_write_out 1, mem_read_out 1.
REQ-009 SHALL have combinational output hazard_stall 1; when high, upstream holds its instruction.

Function
REQ-010 Priority at each edge SHALL be: reset > flush_in > stall_in (hold all) > hazard_stall (load bubble: valid_out=0, reg_write_out=0, mem_read_out=0) > load inputs.
REQ-011 flush_in SHALL clear valid_out, reg_write_out, mem_read_out next cycle, even when stall_in or hazard_stall is high; hazard_stall SHALL be forced 0 while flush_in=1.
REQ-012 A source match SHALL require use_rsN_in=1, rsN_in!=0, matching producer valid and reg-writing, dest equal to rsN_in.
REQ-013 Operand selection per source SHALL be: EX match (valid_out, reg_write_out, dest_out) and not mem_read_out -> alu_result_in; else MEM match -> mem_data_in; else rf_dataN_in; EX beats MEM.
REQ-014 Load-use: hazard_stall SHALL be 1 when valid_in and an EX match exists with mem_read_out=1.
REQ-015 Latency SHALL be one cycle: instruction presented with hazard_stall=0, stall_in=0, flush_in=0 appears on outputs next edge.
REQ-016 valid_in=0 SHALL load a bubble (valid_out=0, write/read controls 0) and SHALL never raise hazard_stall.
REQ-017 With stall_in=1, hazard_stall SHALL still be computed but the register SHALL hold (no bubble insertion).
REQ-018 Data fields of bubbles are don't-care; control fields SHALL be 0.

Reset
REQ-019 On reset, valid_out, reg_write_out, mem_read_out SHALL be 0; operation, readData0, readData1, dest_out SHALL be 0; hazard_stall SHALL evaluate 0 in the cycle after reset.
REQ-020 Reset asserted mid-stall or mid-bubble SHALL discard the held instruction.

Configuration
REQ-021 Macro ID_EX_FORWARD_EN defined: forwarding per REQ-013/014.
REQ-022 Macro ID_EX_FORWARD_EN undefined: operands SHALL always be rf_dataN_in; hazard_stall SHALL be 1 on any EX or MEM match (REQ-012), load or not.

Structure
REQ-023 DATA_W, REG_AW defaults and the 4-bit ALU operation codes (add=0, sub=1, evenUpper=2, evenLower=3, gte=4, ltz=5, ez=6, eq=7, ne=8) SHALL live in shared package cpu_pkg.
REQ-024 Forwarding select logic SHALL be one sub-module fwd_unit instantiated once per source operand.

Verification
REQ-025 No hazard: load op=0, rf_data0=0x0003, rf_data1=0x0004 -> next cycle operation=0, readData0=3, readData1=4, valid_out=1.
REQ-026 EX forward: held dest_out=5, reg_write_out=1, alu_result_in=0x1234; incoming rs0=5 -> readData0=0x1234; with rs0=0 -> rf value used.
REQ-027 Both match: EX dest 5 result 0xAAAA, MEM dest 5 data 0xBBBB, rs1=5 -> readData1=0xAAAA.
REQ-028 Load-use: held mem_read_out=1, dest_out=3; incoming rs1=3 -> hazard_stall=1, next cycle valid_out=0; following cycle instruction loads with MEM forward.
REQ-029 flush_in=1 together with stall_in=1 and hazard_stall condition -> next cycle valid_out=0, hazard_stall=0.
REQ-030 ID_EX_FORWARD_EN undefined: EX dest 2 ALU op, incoming rs0=2 -> hazard_stall=1 for two cycles (EX then MEM), then readData0=rf_data0_in.
